rv32i_mem: RTL and testbench
============================

# rv32i_mem

Byte-addressable 256-byte unified instruction/data memory that sits directly downstream of `rv32i_cpu` on its `mem_*` bus. It serves instruction fetches and loads with a combinational little-endian word read, and commits byte/half/word stores on the clock edge. A host-side byte-serial loader port fills the array with a program while the CPU is held in its own reset.

## Interface
Parameters:
- none (array size fixed at 256 bytes, matching the 8-bit address)

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset; resets loader pointer and flags only, never the array
- `mem_mode`  in  2  access mode from CPU: `MEM_READ`, `MEM_WRITE_BYTE`, `MEM_WRITE_HALF`, `MEM_WRITE_WORD` (from `mem_defines.sv`)
- `mem_address`  in  8  byte address from CPU
- `mem_write_value`  in  32  store data; bits [7:0] / [15:0] / [31:0] used per mode
- `mem_value`  out  32  read word at `mem_address`, little-endian
- `load_valid`  in  1  loader strobe: write `load_byte` at `load_ptr` this edge
- `load_byte`  in  8  loader data
- `load_ptr`  out  8  next loader address
- `load_wrapped`  out  1  sticky: loader pointer has wrapped 0xFF→0x00
- `collision`  out  1  sticky: a CPU write was dropped in favour of the loader

## Operation
- Array: 256 × 8-bit registers, `mem[0..255]`; contents undefined at power-up, untouched by `rst`.
- Read (combinational): `mem_value = {mem[a+3], mem[a+2], mem[a+1], mem[a]}`, addresses mod 256; `a` per Configuration. Reflects array contents before the current edge's write.
- CPU write at edge when `mem_mode != MEM_READ` and `rst` low: BYTE writes `mem[a]`; HALF writes `mem[a..a+1]`; WORD writes `mem[a..a+3]`; byte k of the value goes to `mem[a+k]`, mod 256.
- Loader write at edge when `load_valid`: `mem[load_ptr] <= load_byte`; `load_ptr <= load_ptr + 1` (mod 256); on 0xFF→0x00 set `load_wrapped`. Loader operates during `rst` too, except pointer: when `rst` and `load_valid` both high, byte is written to address 0 and `load_ptr` becomes 1.
- Simultaneous loader and CPU write in the same cycle: loader byte written, entire CPU write dropped (no partial bytes), `collision <= 1`.
- CPU writes while `rst` high are ignored (no collision).
- Top level drives CPU `rst` separately; host holds CPU in reset while loading.

## Timing
- Reset values: `load_ptr = 0`, `load_wrapped = 0`, `collision = 0`; `mem_value` follows array/address, no reset value.
- Read latency 0 cycles (combinational from `mem_address`); CPU sees data at its next edge.
- Write latency 1 edge: data visible on `mem_value` in the cycle after the committing edge.
- CPU store protocol: CPU presents write mode for exactly one cycle (STORE state); block commits on that edge, no handshake or backpressure.
- Flags sticky until `rst`.

## Configuration
- `RV32I_MEM_MISALIGNED_EN` defined: `a = mem_address` unmodified; misaligned half/word accesses span consecutive bytes with wrap mod 256.
- Undefined: address aligned to access size — `a = {mem_address[7:1],1'b0}` for HALF, `{mem_address[7:2],2'b00}` for WORD and for all reads; BYTE unaligned. Misaligned requests silently access the aligned container.

## Test plan
- Reset + load: `rst` pulse, then 8 loader bytes 0x13,0x05,0x50,0x00,0x93,0x05,0x10,0x00 → `load_ptr = 8`; `mem_address=0`, READ → `mem_value = 0x00500513`; `mem_address=4` → `0x00100593`.
- Store widths: WORD 0xDEADBEEF @0x20, then BYTE 0x11 @0x21, HALF 0x2233 @0x22 → read @0x20 = `0x223311EF`, each visible one cycle after its edge.
- Collision: `load_valid` (ptr=0x20, byte 0x55) same cycle as WORD 0xFFFFFFFF @0x20 → read @0x20 = `0x223311 55`, i.e. `0x22331155`, `collision = 1`; cleared only by `rst`.
- Loader wrap: 256 consecutive `load_valid` from ptr 0 → `load_ptr = 0`, `load_wrapped = 1`; `rst` → flag 0, array unchanged.
- Misaligned (macro defined): WORD 0x04030201 @0xFE → read @0xFE = `0x04030201`, `mem[0x00]=0x03`, `mem[0x01]=0x04`; macro undefined: same store lands @0xFC, read @0xFE returns `0x04030201`.
- Write during reset: `rst` high with WORD store @0x40 → `mem[0x40..0x43]` unchanged, `collision = 0`.

Source files
------------

// File: rtl/rv32i_mem_if.sv
// CPU mem_* bus plus host byte-loader port for rv32i_mem.
interface rv32i_mem_if;
  logic [1:0]  mem_mode;
  logic [7:0]  mem_address;
  logic [31:0] mem_write_value;
  logic [31:0] mem_value;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic [7:0]  load_ptr;
  logic        load_wrapped;
  logic        collision;

  modport master (
    output mem_mode, mem_address, mem_write_value, load_valid, load_byte,
    input  mem_value, load_ptr, load_wrapped, collision
  );

  modport slave (
    input  mem_mode, mem_address, mem_write_value, load_valid, load_byte,
    output mem_value, load_ptr, load_wrapped, collision
  );
endinterface

// File: rtl/rv32i_mem.sv
// 256-byte unified memory: combinational LE word read, byte/half/word store on edge, byte loader.
// Optional RV32I_MEM_MISALIGNED_EN: unaligned half/word accesses span bytes (wrap mod 256).
module rv32i_mem (
  input logic       clk,
  input logic       rst,
  rv32i_mem_if.slave bus
);
  localparam logic [1:0] MEM_READ       = 2'd0;
  localparam logic [1:0] MEM_WRITE_BYTE = 2'd1;
  localparam logic [1:0] MEM_WRITE_HALF = 2'd2;
  localparam logic [1:0] MEM_WRITE_WORD = 2'd3;

  logic [7:0] mem [256];
  logic [7:0] load_ptr;
  logic       load_wrapped;
  logic       collision;
  logic [7:0] rd_addr;
  logic [7:0] wr_addr;
  logic [3:0] wr_be;
  logic       cpu_wr;

  always_comb begin
    cpu_wr = (bus.mem_mode != MEM_READ);
`ifdef RV32I_MEM_MISALIGNED_EN
    rd_addr = bus.mem_address;
    wr_addr = bus.mem_address;
`else
    // Misaligned requests silently hit the aligned container
    rd_addr = {bus.mem_address[7:2], 2'b00};
    case (bus.mem_mode)
      MEM_WRITE_HALF: wr_addr = {bus.mem_address[7:1], 1'b0};
      MEM_WRITE_WORD: wr_addr = {bus.mem_address[7:2], 2'b00};
      default:        wr_addr = bus.mem_address;
    endcase
`endif
    case (bus.mem_mode)
      MEM_WRITE_BYTE: wr_be = 4'b0001;
      MEM_WRITE_HALF: wr_be = 4'b0011;
      MEM_WRITE_WORD: wr_be = 4'b1111;
      default:        wr_be = 4'b0000;
    endcase
  end

  assign bus.mem_value = {mem[rd_addr + 8'd3], mem[rd_addr + 8'd2],
                          mem[rd_addr + 8'd1], mem[rd_addr]};

  // Loader wins the array outright; a coincident CPU store is dropped whole
  always_ff @(posedge clk) begin
    if (bus.load_valid) begin
      mem[rst ? 8'd0 : load_ptr] <= bus.load_byte;
    end else if (cpu_wr && !rst) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) mem[wr_addr + 8'(k)] <= bus.mem_write_value[8*k +: 8];
      end
    end

    if (rst) begin
      load_ptr     <= bus.load_valid ? 8'd1 : 8'd0;
      load_wrapped <= 1'b0;
      collision    <= 1'b0;
    end else if (bus.load_valid) begin
      load_ptr <= load_ptr + 8'd1;
      if (load_ptr == 8'hFF) load_wrapped <= 1'b1;
      if (cpu_wr) collision <= 1'b1;
    end
  end

  assign bus.load_ptr     = load_ptr;
  assign bus.load_wrapped = load_wrapped;
  assign bus.collision    = collision;
endmodule

// File: tb/tb_rv32i_mem.sv
// Self-checking bench for rv32i_mem: byte-array model feeds a scoreboard of expected read words.
module tb_rv32i_mem;
  localparam logic [1:0] MEM_READ       = 2'd0;
  localparam logic [1:0] MEM_WRITE_BYTE = 2'd1;
  localparam logic [1:0] MEM_WRITE_HALF = 2'd2;
  localparam logic [1:0] MEM_WRITE_WORD = 2'd3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32i_mem_if bus ();
  rv32i_mem u_dut (.clk(clk), .rst(rst), .bus(bus));

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  model [256];
  logic [7:0]  exp_ptr;
  logic [31:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.mem_mode   = MEM_READ;
    bus.load_valid = 1'b0;
  endtask

  task automatic model_store(input logic [1:0] mode, input logic [7:0] a, input logic [31:0] v);
    logic [7:0] b;
    int n;
`ifdef RV32I_MEM_MISALIGNED_EN
    b = a;
`else
    case (mode)
      MEM_WRITE_HALF: b = {a[7:1], 1'b0};
      MEM_WRITE_WORD: b = {a[7:2], 2'b00};
      default:        b = a;
    endcase
`endif
    n = (mode == MEM_WRITE_BYTE) ? 1 : (mode == MEM_WRITE_HALF) ? 2 : 4;
    for (int k = 0; k < n; k++) model[b + 8'(k)] = v[8*k +: 8];
  endtask

  function automatic logic [31:0] model_word(input logic [7:0] a);
    logic [7:0] b;
`ifdef RV32I_MEM_MISALIGNED_EN
    b = a;
`else
    b = {a[7:2], 2'b00};
`endif
    return {model[b + 8'd3], model[b + 8'd2], model[b + 8'd1], model[b]};
  endfunction

  task automatic load(input logic [7:0] b);
    bus.load_valid = 1'b1;
    bus.load_byte  = b;
    model[exp_ptr] = b;
    exp_ptr        = exp_ptr + 8'd1;
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic store(input logic [1:0] mode, input logic [7:0] a, input logic [31:0] v);
    bus.mem_mode        = mode;
    bus.mem_address     = a;
    bus.mem_write_value = v;
    model_store(mode, a, v);
    tick();
    bus.mem_mode = MEM_READ;
  endtask

  task automatic peek(input logic [7:0] a, output logic [31:0] v);
    bus.mem_address = a;
    #1;
    v = bus.mem_value;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    exp_ptr = 8'd0;
    n_cmp++; if (bus.load_ptr !== 8'd0) begin n_err++; $display("FAIL reset_ptr got %h want 00", bus.load_ptr); end
    n_cmp++; if (bus.load_wrapped !== 1'b0) begin n_err++; $display("FAIL reset_wrapped got %b want 0", bus.load_wrapped); end
    n_cmp++; if (bus.collision !== 1'b0) begin n_err++; $display("FAIL reset_collision got %b want 0", bus.collision); end
  endtask

  task automatic test_load();
    logic [7:0]  prog [8] = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    logic [31:0] obs, exp;
    for (int i = 0; i < 8; i++) load(prog[i]);
    n_cmp++; if (bus.load_ptr !== 8'd8) begin n_err++; $display("FAIL load_ptr got %h want 08", bus.load_ptr); end
    exp_q.push_back(32'h00500513);
    exp_q.push_back(32'h00100593);
`ifdef RV32I_MEM_MISALIGNED_EN
    exp_q.push_back(32'h05930050);
`else
    exp_q.push_back(32'h00500513);
`endif
    peek(8'h00, obs); exp = exp_q.pop_front();
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL load_rd0 got %h want %h", obs, exp); end
    peek(8'h04, obs); exp = exp_q.pop_front();
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL load_rd4 got %h want %h", obs, exp); end
    peek(8'h02, obs); exp = exp_q.pop_front();
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL load_rd2 got %h want %h", obs, exp); end
  endtask

  task automatic test_store_widths();
    logic [31:0] obs, exp;
    store(MEM_WRITE_WORD, 8'h20, 32'hDEADBEEF);
    exp_q.push_back(32'hDEADBEEF);
    peek(8'h20, obs); exp = exp_q.pop_front();
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL st_word got %h want %h", obs, exp); end
    store(MEM_WRITE_BYTE, 8'h21, 32'h00000011);
    exp_q.push_back(32'hDEAD11EF);
    peek(8'h20, obs); exp = exp_q.pop_front();
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL st_byte got %h want %h", obs, exp); end
    store(MEM_WRITE_HALF, 8'h22, 32'h00002233);
    exp_q.push_back(32'h223311EF);
    peek(8'h20, obs); exp = exp_q.pop_front();
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL st_half got %h want %h", obs, exp); end
  endtask

  task automatic test_collision();
    logic [31:0] obs, exp;
    for (int p = 8; p < 32; p++) load(8'(p) ^ 8'hA5);
    for (int w = 8; w < 32; w += 4) exp_q.push_back(model_word(8'(w)));
    for (int w = 8; w < 32; w += 4) begin
      peek(8'(w), obs); exp = exp_q.pop_front();
      n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL coll_fill@%h got %h want %h", w, obs, exp); end
    end
    bus.load_valid      = 1'b1;
    bus.load_byte       = 8'h55;
    bus.mem_mode        = MEM_WRITE_WORD;
    bus.mem_address     = 8'h20;
    bus.mem_write_value = 32'hFFFFFFFF;
    model[exp_ptr] = 8'h55;
    exp_ptr = exp_ptr + 8'd1;
    tick();
    idle();
    exp_q.push_back(32'h22331155);
    peek(8'h20, obs); exp = exp_q.pop_front();
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL coll_data got %h want %h", obs, exp); end
    n_cmp++; if (bus.collision !== 1'b1) begin n_err++; $display("FAIL coll_flag got %b want 1", bus.collision); end
    n_cmp++; if (bus.load_ptr !== 8'h21) begin n_err++; $display("FAIL coll_ptr got %h want 21", bus.load_ptr); end
    tick(); tick(); tick();
    n_cmp++; if (bus.collision !== 1'b1) begin n_err++; $display("FAIL coll_sticky got %b want 1", bus.collision); end
  endtask

  task automatic test_wrap();
    logic [31:0] obs, exp;
    rst = 1'b1; tick(); rst = 1'b0;
    exp_ptr = 8'd0;
    n_cmp++; if (bus.collision !== 1'b0) begin n_err++; $display("FAIL wrap_coll_clr got %b want 0", bus.collision); end
    n_cmp++; if (bus.load_ptr !== 8'd0) begin n_err++; $display("FAIL wrap_ptr0 got %h want 00", bus.load_ptr); end
    for (int i = 0; i < 255; i++) load(8'(i * 7 + 3));
    n_cmp++; if (bus.load_ptr !== 8'hFF || bus.load_wrapped !== 1'b0)
      begin n_err++; $display("FAIL wrap_pre got ptr %h wr %b want ff 0", bus.load_ptr, bus.load_wrapped); end
    load(8'(255 * 7 + 3));
    n_cmp++; if (bus.load_ptr !== 8'h00 || bus.load_wrapped !== 1'b1)
      begin n_err++; $display("FAIL wrap_post got ptr %h wr %b want 00 1", bus.load_ptr, bus.load_wrapped); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (bus.load_wrapped !== 1'b0) begin n_err++; $display("FAIL wrap_clr got %b want 0", bus.load_wrapped); end
    for (int w = 0; w < 256; w += 68) exp_q.push_back(model_word(8'(w)));
    for (int w = 0; w < 256; w += 68) begin
      peek(8'(w), obs); exp = exp_q.pop_front();
      n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL wrap_keep@%h got %h want %h", w, obs, exp); end
    end
  endtask

  task automatic test_write_during_reset();
    logic [31:0] obs, exp;
    load(8'hAA);
    load(8'hBB);
    exp_q.push_back(model_word(8'h40));
    rst                 = 1'b1;
    bus.load_valid      = 1'b1;
    bus.load_byte       = 8'h77;
    bus.mem_mode        = MEM_WRITE_WORD;
    bus.mem_address     = 8'h40;
    bus.mem_write_value = 32'hCAFEBABE;
    tick();
    rst = 1'b0;
    idle();
    model[0] = 8'h77;
    exp_ptr  = 8'd1;
    n_cmp++; if (bus.load_ptr !== 8'd1) begin n_err++; $display("FAIL rst_ld_ptr got %h want 01", bus.load_ptr); end
    n_cmp++; if (bus.collision !== 1'b0) begin n_err++; $display("FAIL rst_coll got %b want 0", bus.collision); end
    peek(8'h40, obs); exp = exp_q.pop_front();
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL rst_store got %h want %h", obs, exp); end
    exp_q.push_back(model_word(8'h00));
    peek(8'h00, obs); exp = exp_q.pop_front();
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL rst_ld_byte got %h want %h", obs, exp); end
  endtask

  task automatic test_misaligned();
    logic [31:0] obs, exp;
    store(MEM_WRITE_WORD, 8'hFE, 32'h04030201);
    exp_q.push_back(32'h04030201);
    peek(8'hFE, obs); exp = exp_q.pop_front();
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL mis_fe got %h want %h", obs, exp); end
`ifdef RV32I_MEM_MISALIGNED_EN
    peek(8'h00, obs);
    n_cmp++; if (obs[15:0] !== 16'h0403) begin n_err++; $display("FAIL mis_wrap got %h want 0403", obs[15:0]); end
`else
    peek(8'hFC, obs);
    n_cmp++; if (obs !== 32'h04030201) begin n_err++; $display("FAIL mis_fc got %h want 04030201", obs); end
`endif
    exp_q.push_back(model_word(8'h00));
    exp_q.push_back(model_word(8'hFC));
    peek(8'h00, obs); exp = exp_q.pop_front();
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL mis_00 got %h want %h", obs, exp); end
    peek(8'hFC, obs); exp = exp_q.pop_front();
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL mis_fc_model got %h want %h", obs, exp); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] obs, exp;
    exp_q.push_back(model_word(8'h80));
    bus.mem_mode        = MEM_WRITE_WORD;
    bus.mem_address     = 8'h80;
    bus.mem_write_value = 32'h11223344;
    #1;
    obs = bus.mem_value; exp = exp_q.pop_front();
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL b2b_precommit got %h want %h", obs, exp); end
    store(MEM_WRITE_WORD, 8'h80, 32'h11223344);
    store(MEM_WRITE_HALF, 8'h86, 32'hA5A5BEEF);
    store(MEM_WRITE_BYTE, 8'h83, 32'h00000099);
    store(MEM_WRITE_WORD, 8'h84, 32'h0BADF00D);
    store(MEM_WRITE_BYTE, 8'h85, 32'h0000003C);
    exp_q.push_back(model_word(8'h80));
    exp_q.push_back(model_word(8'h84));
    peek(8'h80, obs); exp = exp_q.pop_front();
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL b2b_80 got %h want %h", obs, exp); end
    peek(8'h84, obs); exp = exp_q.pop_front();
    n_cmp++; if (obs !== exp) begin n_err++; $display("FAIL b2b_84 got %h want %h", obs, exp); end
  endtask

  initial begin
    rst                 = 1'b1;
    bus.mem_mode        = MEM_READ;
    bus.mem_address     = 8'h00;
    bus.mem_write_value = 32'h0;
    bus.load_valid      = 1'b0;
    bus.load_byte       = 8'h00;
    exp_ptr             = 8'h00;
    test_reset();
    test_load();
    test_store_widths();
    test_collision();
    test_wrap();
    test_write_during_reset();
    test_misaligned();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
